// File: rtl/uncached_dbus_axi_if.sv
// AXI3 channel bundles and the CPU data-bus interface for uncached_dbus_axi.
//
// axi3_pkg::axi_req_t  : master-driven AR, R-ready, AW, W and B-ready signals
// axi3_pkg::axi_resp_t : slave-driven AR/AW/W readies plus R and B channels
// cpu_dbus_if          : CPU request (read, write, byteenable, address, wrdata)
//                        and response (stall, rddata); the CPU is the master,
//                        the bus bridge is the slave.
`timescale 1ns/1ps

package axi3_pkg;

  typedef struct packed {
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        bready;
  } axi_req_t;

  typedef struct packed {
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        awready;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
  } axi_resp_t;

endpackage

interface cpu_dbus_if;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] address;
  logic [31:0] wrdata;
  logic        stall;
  logic [31:0] rddata;

  modport master (
    output read, write, byteenable, address, wrdata,
    input  stall, rddata
  );

  modport slave (
    input  read, write, byteenable, address, wrdata,
    output stall, rddata
  );
endinterface

// File: rtl/uncached_dbus_axi.sv
// Uncached CPU data-bus to AXI3 bridge. Each accepted dbus request becomes
// exactly one single-beat 32-bit AXI transaction; nothing is cached and only
// the request in flight is held.
//
// Ports:
//   clk      : clock, all state changes on the rising edge
//   rst      : synchronous, active-low reset
//   dbus     : CPU data request (read/write/byteenable/address/wrdata),
//              returns stall and rddata
//   axi_req  : AXI3 master outputs (AR, R-ready, AW, W, B-ready)
//   axi_resp : AXI3 slave responses
`timescale 1ns/1ps

module uncached_dbus_axi
  import axi3_pkg::*;
#(
  parameter logic [3:0] ARCACHE_VAL = 4'b0000,
  parameter logic [2:0] ARPROT_VAL  = 3'b000
) (
  input  logic       clk,
  input  logic       rst,
  cpu_dbus_if.slave  dbus,
  output axi_req_t   axi_req,
  input  axi_resp_t  axi_resp
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_RD,
    ST_WR,
    ST_BR,
    ST_DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg;
  logic [31:0] wrdata_reg;
  logic [3:0]  be_reg;
  logic [31:0] rddata_reg;
  logic        aw_done_reg, w_done_reg;
  logic        arvalid_reg, rready_reg, awvalid_reg, wvalid_reg, bready_reg;

  logic        accept_read, accept_write, capture_rdata;
  logic        aw_hs, w_hs, aw_done_now, w_done_now;

  // Response codes are deliberately not acted upon: error responses finish
  // the transaction like OKAY does.
  logic        unused_resp;
  assign unused_resp = ^{axi_resp.rresp, axi_resp.bresp, axi_resp.rlast};

  assign aw_hs       = awvalid_reg & axi_resp.awready;
  assign w_hs        = wvalid_reg & axi_resp.wready;
  // Include this cycle's handshake so simultaneous AW/W completion leaves WR
  // immediately.
  assign aw_done_now = aw_done_reg | aw_hs;
  assign w_done_now  = w_done_reg | w_hs;

  always_comb begin
    state_next    = state_reg;
    accept_read   = 1'b0;
    accept_write  = 1'b0;
    capture_rdata = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Write wins when both are requested.
        if (dbus.write) begin
          accept_write = 1'b1;
          state_next   = ST_WR;
        end else if (dbus.read) begin
          accept_read = 1'b1;
          state_next  = ST_AR;
        end
      end
      ST_AR: begin
        if (arvalid_reg && axi_resp.arready) state_next = ST_RD;
      end
      ST_RD: begin
        if (rready_reg && axi_resp.rvalid) begin
          capture_rdata = 1'b1;
          state_next    = ST_DONE;
        end
      end
      ST_WR: begin
        if (aw_done_now && w_done_now) state_next = ST_BR;
      end
      ST_BR: begin
        if (bready_reg && axi_resp.bvalid) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= '0;
      wrdata_reg  <= '0;
      be_reg      <= '0;
      rddata_reg  <= '0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      arvalid_reg <= 1'b0;
      rready_reg  <= 1'b0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      bready_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept_read || accept_write) addr_reg <= dbus.address;
      if (accept_write) begin
        wrdata_reg <= dbus.wrdata;
        be_reg     <= dbus.byteenable;
      end
      if (capture_rdata) rddata_reg <= axi_resp.rdata;
      // Sticky completion flags live only while in WR; they clear on exit.
      aw_done_reg <= (state_next == ST_WR) && aw_done_now;
      w_done_reg  <= (state_next == ST_WR) && w_done_now;
      // Valids/readies are registered from the next state, so they rise on
      // entry and fall in the cycle after their handshake.
      arvalid_reg <= (state_next == ST_AR);
      rready_reg  <= (state_next == ST_RD);
      awvalid_reg <= (state_next == ST_WR) && !aw_done_now;
      wvalid_reg  <= (state_next == ST_WR) && !w_done_now;
      bready_reg  <= (state_next == ST_BR);
    end
  end

  always_comb begin
    axi_req         = '0;
    axi_req.araddr  = addr_reg;
    axi_req.arlen   = 4'd0;
    axi_req.arsize  = 3'b010;
    axi_req.arburst = 2'b01;
    axi_req.arlock  = 2'b00;
    axi_req.arcache = ARCACHE_VAL;
    axi_req.arprot  = ARPROT_VAL;
    axi_req.arvalid = arvalid_reg;
    axi_req.rready  = rready_reg;
    axi_req.awaddr  = addr_reg;
    axi_req.awlen   = 4'd0;
    axi_req.awsize  = 3'b010;
    axi_req.awburst = 2'b01;
    axi_req.awlock  = 2'b00;
    axi_req.awcache = ARCACHE_VAL;
    axi_req.awprot  = ARPROT_VAL;
    axi_req.awvalid = awvalid_reg;
    axi_req.wdata   = wrdata_reg;
    axi_req.wstrb   = be_reg;
    axi_req.wlast   = 1'b1;
    axi_req.wvalid  = wvalid_reg;
    axi_req.bready  = bready_reg;
  end

  assign dbus.stall  = (dbus.read | dbus.write) & (state_reg != ST_DONE);
  assign dbus.rddata = rddata_reg;

endmodule

// File: tb/tb_uncached_dbus_axi.sv
// Scoreboard bench for uncached_dbus_axi: the driver pushes expected AR/AW/W
// beats and completions into queues; a negedge monitor pops and compares.
`timescale 1ns/1ps

module tb_uncached_dbus_axi;
  import axi3_pkg::*;

  localparam logic [3:0] CACHE_P = 4'b0011;
  localparam logic [2:0] PROT_P  = 3'b010;

  logic      clk = 1'b0;
  logic      rst = 1'b0;
  axi_req_t  axi_req;
  axi_resp_t axi_resp;

  always #5 clk = ~clk;

  cpu_dbus_if dbus();

  uncached_dbus_axi #(
    .ARCACHE_VAL(CACHE_P),
    .ARPROT_VAL (PROT_P)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .dbus    (dbus),
    .axi_req (axi_req),
    .axi_resp(axi_resp)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } w_t;

  typedef struct {
    logic        is_read;
    logic [31:0] rdata;
    int          stall_cycles;
  } done_t;

  logic [31:0] exp_ar[$];
  logic [31:0] exp_aw[$];
  w_t          exp_w[$];
  done_t       exp_done[$];

  // slave behaviour knobs: ready/valid asserted after N waiting cycles
  int          ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0;
  logic [31:0] r_data = '0;
  logic [1:0]  r_resp = 2'b00, b_resp = 2'b00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an unexpected beat expected none", name);
  endtask

  // ---------------- slave model ----------------
  initial begin
    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    axi_resp = '0;
    forever begin
      @(posedge clk);
      #1;
      if (axi_req.arvalid) begin axi_resp.arready = (ar_cnt == ar_lat); ar_cnt++; end
      else begin axi_resp.arready = 1'b0; ar_cnt = 0; end
      if (axi_req.awvalid) begin axi_resp.awready = (aw_cnt == aw_lat); aw_cnt++; end
      else begin axi_resp.awready = 1'b0; aw_cnt = 0; end
      if (axi_req.wvalid) begin axi_resp.wready = (w_cnt == w_lat); w_cnt++; end
      else begin axi_resp.wready = 1'b0; w_cnt = 0; end
      if (axi_req.rready) begin
        axi_resp.rvalid = (r_cnt == r_lat);
        axi_resp.rdata  = axi_resp.rvalid ? r_data : 32'h0;
        axi_resp.rresp  = r_resp;
        axi_resp.rlast  = axi_resp.rvalid;
        r_cnt++;
      end else begin
        axi_resp.rvalid = 1'b0; axi_resp.rlast = 1'b0; r_cnt = 0;
      end
      if (axi_req.bready) begin axi_resp.bvalid = (b_cnt == b_lat); axi_resp.bresp = b_resp; b_cnt++; end
      else begin axi_resp.bvalid = 1'b0; b_cnt = 0; end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int          stall_cnt = 0;
    logic        ar_pend = 0, aw_pend = 0, w_pend = 0;
    logic [31:0] prev_araddr = '0, prev_awaddr = '0;
    w_t          prev_w = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_cnt = 0; ar_pend = 0; aw_pend = 0; w_pend = 0;
        if (!(dbus.read | dbus.write)) check("stall_in_reset", 64'(dbus.stall), 64'd0);
      end else begin
        if (ar_pend) check("ar_hold", {31'd0, axi_req.arvalid, axi_req.araddr}, {31'd0, 1'b1, prev_araddr});
        if (aw_pend) check("aw_hold", {31'd0, axi_req.awvalid, axi_req.awaddr}, {31'd0, 1'b1, prev_awaddr});
        if (w_pend)  check("w_hold", {27'd0, axi_req.wvalid, axi_req.wdata, axi_req.wstrb}, {27'd0, 1'b1, prev_w});
        if (axi_req.arvalid && axi_resp.arready) begin
          if (exp_ar.size() == 0) unexpected("ar_beat");
          else check("ar_fields",
                     {14'd0, axi_req.araddr, axi_req.arlen, axi_req.arsize, axi_req.arburst,
                      axi_req.arlock, axi_req.arcache, axi_req.arprot},
                     {14'd0, exp_ar.pop_front(), 4'd0, 3'b010, 2'b01, 2'b00, CACHE_P, PROT_P});
        end
        if (axi_req.awvalid && axi_resp.awready) begin
          if (exp_aw.size() == 0) unexpected("aw_beat");
          else check("aw_fields",
                     {14'd0, axi_req.awaddr, axi_req.awlen, axi_req.awsize, axi_req.awburst,
                      axi_req.awlock, axi_req.awcache, axi_req.awprot},
                     {14'd0, exp_aw.pop_front(), 4'd0, 3'b010, 2'b01, 2'b00, CACHE_P, PROT_P});
        end
        if (axi_req.wvalid && axi_resp.wready) begin
          if (exp_w.size() == 0) unexpected("w_beat");
          else check("w_fields", {27'd0, axi_req.wdata, axi_req.wstrb, axi_req.wlast},
                     {27'd0, exp_w.pop_front(), 1'b1});
        end
        ar_pend = axi_req.arvalid & ~axi_resp.arready;
        aw_pend = axi_req.awvalid & ~axi_resp.awready;
        w_pend  = axi_req.wvalid & ~axi_resp.wready;
        prev_araddr = axi_req.araddr;
        prev_awaddr = axi_req.awaddr;
        prev_w      = {axi_req.wdata, axi_req.wstrb};
        if (dbus.read | dbus.write) begin
          if (dbus.stall) stall_cnt++;
          else begin
            if (exp_done.size() == 0) unexpected("completion");
            else begin
              done_t d;
              d = exp_done.pop_front();
              check("stall_cycles", 64'(stall_cnt), 64'(d.stall_cycles));
              if (d.is_read) check("rddata", 64'(dbus.rddata), 64'(d.rdata));
              $display("txn %s done: stall=%0d rddata=%h", d.is_read ? "RD" : "WR", stall_cnt, dbus.rddata);
            end
            stall_cnt = 0;
          end
        end else begin
          stall_cnt = 0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Caller is positioned #1 after a rising edge.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdat, input logic [3:0] be,
                        input logic [31:0] exp_rd, input int exp_stall, input bit toggle);
    done_t d;
    int    n;
    if (wr) begin
      exp_aw.push_back(addr);
      exp_w.push_back({wdat, be});
    end else begin
      exp_ar.push_back(addr);
    end
    d.is_read = rd && !wr; d.rdata = exp_rd; d.stall_cycles = exp_stall;
    exp_done.push_back(d);
    dbus.read = rd; dbus.write = wr; dbus.address = addr; dbus.wrdata = wdat; dbus.byteenable = be;
    n = 0;
    forever begin
      @(negedge clk);
      if (!dbus.stall) break;
      if (toggle && n > 0) begin
        dbus.address    = ~dbus.address;
        dbus.wrdata     = ~dbus.wrdata;
        dbus.byteenable = ~dbus.byteenable;
      end
      n++;
      if (n > 200) begin
        unexpected("request_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
    dbus.read = 1'b0; dbus.write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    dbus.read = 1'b0; dbus.write = 1'b0; dbus.byteenable = '0;
    dbus.address = '0; dbus.wrdata = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valids", {59'd0, axi_req.arvalid, axi_req.awvalid, axi_req.wvalid,
                           axi_req.rready, axi_req.bready}, 64'd0);
    check("reset_rddata", 64'(dbus.rddata), 64'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;

    // zero-wait read, then a back-to-back read
    r_data = 32'hDEADBEEF;
    do_req(1, 0, 32'h1FC0_0004, 0, 4'h0, 32'hDEADBEEF, 3, 0);
    r_data = 32'hCAFEF00D;
    do_req(1, 0, 32'h1000_0008, 0, 4'h0, 32'hCAFEF00D, 3, 0);

    // W before AW, B one cycle late
    aw_lat = 2; w_lat = 0; b_lat = 1;
    do_req(0, 1, 32'h8000_0010, 32'h1234_5678, 4'b0011, 0, 6, 0);
    aw_lat = 0; b_lat = 0;

    // AW and W in the same cycle
    do_req(0, 1, 32'h0000_0100, 32'hA5A5_5A5A, 4'b1111, 0, 3, 0);

    // AR backpressure with toggling dbus inputs
    ar_lat = 10; r_data = 32'h0BAD_C0DE;
    do_req(1, 0, 32'h2000_0040, 0, 4'h0, 32'h0BAD_C0DE, 13, 1);
    ar_lat = 0;

    // read and write together: write only
    do_req(1, 1, 32'h3000_0000, 32'h1111_2222, 4'b1010, 0, 3, 0);

    // empty byte enable still writes
    do_req(0, 1, 32'h3000_0004, 32'hFFFF_0000, 4'b0000, 0, 3, 0);

    // error responses complete normally
    r_resp = 2'b10; b_resp = 2'b11; r_data = 32'h55AA_55AA;
    do_req(1, 0, 32'h4000_0000, 0, 4'h0, 32'h55AA_55AA, 3, 0);
    do_req(0, 1, 32'h4000_0004, 32'h0F0F_0F0F, 4'b0101, 0, 3, 0);
    r_resp = 2'b00; b_resp = 2'b00;

    // AW late, W late, toggled inputs during the write
    aw_lat = 3; w_lat = 1;
    do_req(0, 1, 32'h6000_0020, 32'h89AB_CDEF, 4'b1100, 0, 6, 1);
    aw_lat = 0; w_lat = 0;

    // read with R wait states
    r_lat = 2; r_data = 32'h2468_ACE0;
    do_req(1, 0, 32'h7000_0000, 0, 4'h0, 32'h2468_ACE0, 5, 0);

    // reset while waiting in RD
    r_lat = 5;
    exp_ar.push_back(32'h5000_0000);
    dbus.read = 1'b1; dbus.address = 32'h5000_0000;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (axi_req.rready) break;
      n++;
      if (n > 50) begin unexpected("rd_entry_timeout"); break; end
    end
    @(posedge clk); #1; rst = 1'b0; dbus.read = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check("rst_rd_valids", {59'd0, axi_req.arvalid, axi_req.awvalid, axi_req.wvalid,
                            axi_req.rready, axi_req.bready}, 64'd0);
    check("rst_rd_rddata", 64'(dbus.rddata), 64'd0);
    check("rst_rd_stall", 64'(dbus.stall), 64'd0);
    @(posedge clk); #1;
    r_lat = 0; r_data = 32'h1357_9BDF;
    do_req(1, 0, 32'h5000_0004, 0, 4'h0, 32'h1357_9BDF, 3, 0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("ar_queue_empty", 64'(exp_ar.size()), 64'd0);
    check("aw_queue_empty", 64'(exp_aw.size()), 64'd0);
    check("w_queue_empty", 64'(exp_w.size()), 64'd0);
    check("done_queue_empty", 64'(exp_done.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
